// File: rtl/music_pkg.sv
// Shared constants for the music track selector: play modes, FSM states, LFSR taps.
package music_pkg;

  localparam logic [1:0] MODE_REPEAT_ALL  = 2'b00;
  localparam logic [1:0] MODE_REPEAT_ONE  = 2'b01;
  localparam logic [1:0] MODE_STOP_AT_END = 2'b10;
  localparam logic [1:0] MODE_SHUFFLE     = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, as a mask over lfsr bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector: one-cycle pulse when a synchronous level goes high.
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Remember last cycle's level so a held input yields a single event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/music_track_selector.sv
// Track index FSM with repeat/stop/shuffle play modes and a start pulse to the player.
module music_track_selector
  import music_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned SEL_W      = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prox,
  input  logic             prev,
  input  logic             force_prox,
  input  logic [1:0]       mode,
  output logic [SEL_W-1:0] select,
  output logic             start,
  output logic             playing
);

  localparam int unsigned     XW   = SEL_W + 1;
  localparam logic [XW-1:0]   LAST = XW'(NUM_TRACKS - 1);
  localparam logic [XW-1:0]   ONE  = XW'(1);

  logic ev_prox, ev_prev, ev_force;

  button_edge_detect u_prox_edge (
    .clk   (clk),
    .reset (reset),
    .in    (prox),
    .pulse (ev_prox)
  );

  button_edge_detect u_prev_edge (
    .clk   (clk),
    .reset (reset),
    .in    (prev),
    .pulse (ev_prev)
  );

  button_edge_detect u_force_edge (
    .clk   (clk),
    .reset (reset),
    .in    (force_prox),
    .pulse (ev_force)
  );

  state_e        state_q;
  logic [7:0]    lfsr_q;
  logic [XW-1:0] sel_ext, sel_inc, sel_dec, pick_raw, sel_shuf, sel_d;
  logic          load_req, stop_req;

  // Free-running shuffle source, advances every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Candidate indices, computed one bit wider than select so wrap compares are safe
  always_comb begin
    sel_ext  = {1'b0, select};
    sel_inc  = (sel_ext == LAST) ? '0 : sel_ext + ONE;
    sel_dec  = (sel_ext == '0) ? LAST : sel_ext - ONE;
    pick_raw = XW'(lfsr_q % 8'(NUM_TRACKS));
    // Bump a collision to the next track so shuffle never replays the current one
    if (pick_raw == sel_ext) begin
      sel_shuf = (pick_raw == LAST) ? '0 : pick_raw + ONE;
    end else begin
      sel_shuf = pick_raw;
    end
  end

  // Event arbitration: a lone button wins, opposing buttons cancel everything
  always_comb begin
    sel_d    = sel_ext;
    load_req = 1'b0;
    stop_req = 1'b0;
    if (ev_prox && ev_prev) begin
      sel_d = sel_ext;
    end else if (ev_prox) begin
      sel_d    = (mode == MODE_SHUFFLE) ? sel_shuf : sel_inc;
      load_req = 1'b1;
    end else if (ev_prev) begin
      sel_d    = sel_dec;
      load_req = 1'b1;
    end else if (ev_force && (state_q != ST_STOPPED)) begin
      case (mode)
        MODE_REPEAT_ALL: begin
          sel_d    = sel_inc;
          load_req = 1'b1;
        end
        MODE_REPEAT_ONE: begin
          load_req = 1'b1;
        end
        MODE_STOP_AT_END: begin
          if (sel_ext == LAST) begin
            stop_req = 1'b1;
          end else begin
            sel_d    = sel_inc;
            load_req = 1'b1;
          end
        end
        default: begin
          sel_d    = sel_shuf;
          load_req = 1'b1;
        end
      endcase
    end
  end

  // Main FSM with registered select/start/playing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      select  <= '0;
      start   <= 1'b0;
      playing <= 1'b1;
    end else begin
      select <= sel_d[SEL_W-1:0];
      if (load_req) begin
        state_q <= ST_LOAD;
        start   <= 1'b1;
        playing <= 1'b1;
      end else if (stop_req) begin
        state_q <= ST_STOPPED;
        start   <= 1'b0;
        playing <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            // Coming out of reset LOAD has not pulsed yet; issue it before moving on
            if (!start) begin
              start <= 1'b1;
            end else begin
              start   <= 1'b0;
              state_q <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            start <= 1'b0;
          end
          default: begin
            start   <= 1'b0;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_track_selector.sv
// Directed self-checking bench for music_track_selector with 5 tracks.
module tb_music_track_selector;

  localparam int unsigned NT = 5;
  localparam int unsigned SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          prox, prev, force_prox;
  logic [1:0]    mode;
  logic [SW-1:0] select;
  logic          start;
  logic          playing;

  int n_cmp = 0;
  int n_err = 0;

  music_track_selector #(
    .NUM_TRACKS (NT),
    .SEL_W      (SW),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prox       (prox),
    .prev       (prev),
    .force_prox (force_prox),
    .mode       (mode),
    .select     (select),
    .start      (start),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (start) c++;
    end
  endtask

  task automatic press_prox();
    prox = 1'b1;
    tick();
    prox = 1'b0;
    tick();
  endtask

  initial begin : stim
    int c;
    logic [SW-1:0] old_sel;
    logic [SW-1:0] exp_sel;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 4, 0};

    reset = 1'b1; prox = 1'b0; prev = 1'b0; force_prox = 1'b0; mode = 2'b00;
    tick();
    chk("reset_select", 32'(select), 0);
    chk("reset_start", 32'(start), 0);
    chk("reset_playing", 32'(playing), 1);
    reset = 1'b0;
    tick();
    chk("post_reset_start", 32'(start), 1);
    chk("post_reset_select", 32'(select), 0);
    tick();
    chk("post_reset_start_low", 32'(start), 0);

    // Step 1: REPEAT_ALL prox walk and prev wrap
    for (int i = 0; i < 5; i++) begin
      prox = 1'b1;
      tick();
      chk($sformatf("prox_sel_%0d", i), 32'(select), 32'(exp_seq[i]));
      chk($sformatf("prox_start_%0d", i), 32'(start), 1);
      prox = 1'b0;
      tick();
      chk($sformatf("prox_start_low_%0d", i), 32'(start), 0);
    end
    prev = 1'b1;
    tick();
    chk("prev_wrap_sel", 32'(select), 4);
    chk("prev_wrap_start", 32'(start), 1);
    prev = 1'b0;
    tick();

    // Step 2: held prox and simultaneous prox/prev
    prox = 1'b1;
    count_starts(10, c);
    chk("held_prox_starts", 32'(c), 1);
    chk("held_prox_sel", 32'(select), 0);
    prox = 1'b0;
    tick();
    prox = 1'b1; prev = 1'b1;
    count_starts(3, c);
    chk("both_btn_starts", 32'(c), 0);
    chk("both_btn_sel", 32'(select), 0);
    prox = 1'b0; prev = 1'b0;
    tick();

    // Step 3: REPEAT_ONE restart, button beats force_prox
    mode = 2'b01;
    press_prox();
    press_prox();
    chk("r1_setup_sel", 32'(select), 2);
    force_prox = 1'b1;
    count_starts(4, c);
    chk("r1_force_starts", 32'(c), 1);
    chk("r1_force_sel", 32'(select), 2);
    force_prox = 1'b0;
    tick();
    force_prox = 1'b1; prox = 1'b1;
    count_starts(4, c);
    chk("r1_combo_starts", 32'(c), 1);
    chk("r1_combo_sel", 32'(select), 3);
    force_prox = 1'b0; prox = 1'b0;
    tick();

    // Step 4: STOP_AT_END
    mode = 2'b10;
    force_prox = 1'b1;
    tick();
    chk("stop_adv_sel", 32'(select), 4);
    chk("stop_adv_start", 32'(start), 1);
    force_prox = 1'b0;
    tick();
    force_prox = 1'b1;
    tick();
    chk("stop_end_playing", 32'(playing), 0);
    chk("stop_end_sel", 32'(select), 4);
    chk("stop_end_start", 32'(start), 0);
    force_prox = 1'b0;
    tick();
    force_prox = 1'b1;
    count_starts(3, c);
    chk("stopped_force_starts", 32'(c), 0);
    chk("stopped_force_playing", 32'(playing), 0);
    chk("stopped_force_sel", 32'(select), 4);
    force_prox = 1'b0;
    tick();
    prox = 1'b1;
    tick();
    chk("resume_sel", 32'(select), 0);
    chk("resume_playing", 32'(playing), 1);
    chk("resume_start", 32'(start), 1);
    prox = 1'b0;
    tick();

    // Step 5: SHUFFLE never repeats the current track
    mode = 2'b11;
    for (int i = 0; i < 50; i++) begin
      old_sel = select;
      force_prox = 1'b1;
      tick();
      n_cmp++;
      assert (select !== old_sel) else begin
        n_err++;
        $error("FAIL shuf_repeat_%0d: observed %0d expected not %0d", i, select, old_sel);
      end
      n_cmp++;
      assert (select < SW'(NT)) else begin
        n_err++;
        $error("FAIL shuf_range_%0d: observed %0d expected below %0d", i, select, NT);
      end
      chk($sformatf("shuf_start_%0d", i), 32'(start), 1);
      force_prox = 1'b0;
      tick();
    end
    exp_sel = (select == '0) ? SW'(NT - 1) : select - SW'(1);
    prev = 1'b1;
    tick();
    chk("shuf_prev_sel", 32'(select), 32'(exp_sel));
    chk("shuf_prev_start", 32'(start), 1);
    prev = 1'b0;
    tick();

    // Step 6: async reset while STOPPED on the last track
    mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      if (select != SW'(3)) press_prox();
    end
    chk("pre_stop_sel", 32'(select), 3);
    force_prox = 1'b1; tick(); force_prox = 1'b0; tick();
    force_prox = 1'b1; tick(); force_prox = 1'b0; tick();
    chk("pre_reset_playing", 32'(playing), 0);
    chk("pre_reset_sel", 32'(select), 4);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_sel", 32'(select), 0);
    chk("async_reset_start", 32'(start), 0);
    chk("async_reset_playing", 32'(playing), 1);
    tick();
    reset = 1'b0;
    tick();
    chk("release_start", 32'(start), 1);
    tick();
    chk("release_start_low", 32'(start), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a stuck run
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
